// File: rtl/bicubic_product_serializer.sv
// Rounds and clamps four signed fixed-point inner products into pixels, buffers
// up to two groups, and emits them one pixel per accepted beat (idx 0..3).
module bicubic_product_serializer #(
    parameter int PRODUCT_WIDTH = 32,
    parameter int FRAC_BITS     = 14,
    parameter int OUT_WIDTH     = 8
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            in_valid,
    output logic                            in_ready,
    input  logic signed [PRODUCT_WIDTH-1:0] inner_product1,
    input  logic signed [PRODUCT_WIDTH-1:0] inner_product2,
    input  logic signed [PRODUCT_WIDTH-1:0] inner_product3,
    input  logic signed [PRODUCT_WIDTH-1:0] inner_product4,
    output logic                            out_valid,
    input  logic                            out_ready,
    output logic [OUT_WIDTH-1:0]            out_pixel,
    output logic [1:0]                      out_idx,
    output logic                            out_last,
    output logic                            err_overflow
);

    typedef enum logic {IDLE = 1'b0, SEND = 1'b1} state_t;

    // Rounding runs one bit wider than the product so the most positive input cannot wrap.
    localparam logic signed [PRODUCT_WIDTH:0] C_ROUND =
        {{PRODUCT_WIDTH{1'b0}}, 1'b1} << (FRAC_BITS - 1);
    localparam logic signed [PRODUCT_WIDTH:0] C_MAX =
        {{(PRODUCT_WIDTH + 1 - OUT_WIDTH){1'b0}}, {OUT_WIDTH{1'b1}}};

    function automatic logic [OUT_WIDTH-1:0] f_convert(input logic signed [PRODUCT_WIDTH-1:0] i_p);
        logic signed [PRODUCT_WIDTH:0] w_sum;
        logic signed [PRODUCT_WIDTH:0] w_shift;
        w_sum   = $signed({i_p[PRODUCT_WIDTH-1], i_p}) + C_ROUND;
        w_shift = w_sum >>> FRAC_BITS;
        if (w_shift[PRODUCT_WIDTH])
            return '0;
        else if (w_shift > C_MAX)
            return {OUT_WIDTH{1'b1}};
        else
            return w_shift[OUT_WIDTH-1:0];
    endfunction

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic [OUT_WIDTH-1:0]   r_mem [2][4];
    logic                   r_wr_ptr;
    logic                   r_rd_ptr;
    logic [1:0]             r_count;
    logic [1:0]             w_count_nxt;
    logic [1:0]             r_beat;
    logic                   r_in_ready;
    logic                   r_err;
    logic                   w_push;
    logic                   w_pop;
    logic                   w_beat_acc;
    logic signed [PRODUCT_WIDTH-1:0] w_prod [4];

    assign w_prod[0]  = inner_product1;
    assign w_prod[1]  = inner_product2;
    assign w_prod[2]  = inner_product3;
    assign w_prod[3]  = inner_product4;

    assign out_valid  = (r_state == SEND);
    assign w_push     = in_valid && r_in_ready;
    assign w_beat_acc = out_valid && out_ready;
    assign w_pop      = w_beat_acc && (r_beat == 2'd3);

    always_comb begin
        w_count_nxt = r_count;
        case ({w_push, w_pop})
            2'b10:   w_count_nxt = r_count + 2'd1;
            2'b01:   w_count_nxt = r_count - 2'd1;
            default: w_count_nxt = r_count;
        endcase
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (w_push) w_state_nxt = SEND;
            SEND:    if (w_pop && (w_count_nxt == 2'd0)) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_state <= IDLE;
        else
            r_state <= w_state_nxt;
    end

    // NOTE: the pixel storage has no reset; its contents are never observed until a push fills it.
    always_ff @(posedge clk) begin
        if (w_push) begin
            for (int k = 0; k < 4; k++)
                r_mem[r_wr_ptr][k] <= f_convert(w_prod[k]);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr   <= 1'b0;
            r_rd_ptr   <= 1'b0;
            r_count    <= 2'd0;
            r_beat     <= 2'd0;
            r_in_ready <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            if (w_push)
                r_wr_ptr <= ~r_wr_ptr;
            if (w_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
                r_beat   <= 2'd0;
            end else if (w_beat_acc) begin
                r_beat   <= r_beat + 2'd1;
            end
            r_count    <= w_count_nxt;
            r_in_ready <= (w_count_nxt < 2'd2);
            if (in_valid && !r_in_ready)
                r_err <= 1'b1;
        end
    end

    assign in_ready     = r_in_ready;
    assign err_overflow = r_err;
    assign out_pixel    = out_valid ? r_mem[r_rd_ptr][r_beat] : '0;
    assign out_idx      = out_valid ? r_beat : 2'd0;
    assign out_last     = out_valid && (r_beat == 2'd3);

endmodule

// File: tb/tb_bicubic_product_serializer.sv
// Scoreboard bench for bicubic_product_serializer at default parameters
// (32-bit products, 14 fractional bits, 8-bit pixels).
module tb_bicubic_product_serializer;

    typedef struct {
        logic [7:0] px;
        logic [1:0] idx;
        logic       last;
    } exp_t;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               in_valid = 1'b0;
    logic               in_ready;
    logic signed [31:0] ip1 = '0, ip2 = '0, ip3 = '0, ip4 = '0;
    logic               out_valid;
    logic               out_ready = 1'b0;
    logic [7:0]         out_pixel;
    logic [1:0]         out_idx;
    logic               out_last;
    logic               err_overflow;

    int   total = 0;
    int   bad   = 0;
    int   beats = 0;
    bit   mon_en = 1'b0;
    exp_t q[$];

    bicubic_product_serializer #(
        .PRODUCT_WIDTH(32), .FRAC_BITS(14), .OUT_WIDTH(8)
    ) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .inner_product1(ip1), .inner_product2(ip2),
        .inner_product3(ip3), .inner_product4(ip4),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_pixel(out_pixel), .out_idx(out_idx), .out_last(out_last),
        .err_overflow(err_overflow)
    );

    always #5 clk = ~clk;

    // Reference: floor((p + 8192) / 16384) computed in 64 bits, then clamped to 0..255.
    function automatic logic [7:0] model(input logic signed [31:0] p);
        longint v;
        v = (longint'(p) + 64'sd8192) >>> 14;
        if (v < 0)   return 8'd0;
        if (v > 255) return 8'd255;
        return 8'(v);
    endfunction

    // Every accepted beat is popped from the scoreboard and compared.
    always @(negedge clk) begin
        if (mon_en && !rst && out_valid && out_ready) begin
            exp_t e;
            total++;
            if (q.size() == 0) begin
                bad++;
                $display("FAIL beat_unexpected: got px=%0d idx=%0d, required no beat", out_pixel, out_idx);
            end else begin
                e = q.pop_front();
                if (out_pixel !== e.px || out_idx !== e.idx || out_last !== e.last) begin
                    bad++;
                    $display("FAIL beat: got px=%0d idx=%0d last=%0b, required px=%0d idx=%0d last=%0b",
                             out_pixel, out_idx, out_last, e.px, e.idx, e.last);
                end
            end
            beats++;
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] req);
        total++;
        if (got !== req) begin
            bad++;
            $display("FAIL %s: got %0d, required %0d", name, got, req);
        end
    endtask

    // Presents one group for one edge; pushes expectations only if it will be captured.
    task automatic present(input logic signed [31:0] a, b, c, d, output bit taken);
        logic signed [31:0] p [4];
        p = '{a, b, c, d};
        ip1 = a; ip2 = b; ip3 = c; ip4 = d;
        in_valid = 1'b1;
        taken = in_ready;
        if (taken)
            for (int k = 0; k < 4; k++)
                q.push_back('{px: model(p[k]), idx: 2'(k), last: (k == 3)});
        tick();
        in_valid = 1'b0;
    endtask

    task automatic drain(input string name, input int budget);
        int n = 0;
        while ((q.size() != 0 || out_valid) && n < budget) begin
            tick();
            n++;
        end
        chk({name, "_drain_timeout"}, 32'(n < budget), 32'd1);
    endtask

    task automatic test_reset;
        #3;
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_in_ready", 32'(in_ready), 0);
        chk("rst_out_pixel", 32'(out_pixel), 0);
        chk("rst_out_idx", 32'(out_idx), 0);
        chk("rst_out_last", 32'(out_last), 0);
        chk("rst_err", 32'(err_overflow), 0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rel_in_ready_before_edge", 32'(in_ready), 0);
        tick();
        chk("rel_in_ready_first_edge", 32'(in_ready), 1);
        mon_en = 1'b1;
    endtask

    task automatic test_basic;
        bit t;
        out_ready = 1'b1;
        chk("basic_idle_valid", 32'(out_valid), 0);
        present(100 * 16384, 0, 255 * 16384, 7 * 16384 + 8192, t);
        chk("basic_taken", 32'(t), 1);
        chk("basic_latency", 32'(out_valid), 1);
        repeat (4) tick();
        chk("basic_consecutive_left", q.size(), 0);
        chk("basic_idle_after", 32'(out_valid), 0);
    endtask

    task automatic test_clamp;
        bit t;
        out_ready = 1'b1;
        present(-5, 32'sh8000_0000, 300 * 16384, 32'sh7fff_ffff, t);
        chk("clamp_taken", 32'(t), 1);
        drain("clamp", 20);
        // Round-half-up boundaries: just under, exactly at half.
        present(16384 + 8191, 16384 + 8192, -8192, 255 * 16384 + 8191, t);
        drain("round", 20);
    endtask

    task automatic test_overflow;
        bit t0, t1, t2;
        int b0;
        out_ready = 1'b0;
        present(1 * 16384, 2 * 16384, 3 * 16384, 4 * 16384, t0);
        chk("ovf_in_ready_after_1st", 32'(in_ready), 1);
        present(5 * 16384, 6 * 16384, 7 * 16384, 8 * 16384, t1);
        chk("ovf_in_ready_after_2nd", 32'(in_ready), 0);
        chk("ovf_err_before_3rd", 32'(err_overflow), 0);
        present(9 * 16384, 9 * 16384, 9 * 16384, 9 * 16384, t2);
        chk("ovf_taken_first_two", 32'({t0, t1}), 32'b11);
        chk("ovf_third_dropped", 32'(t2), 0);
        chk("ovf_err_set", 32'(err_overflow), 1);
        b0 = beats;
        out_ready = 1'b1;
        drain("ovf", 30);
        repeat (3) tick();
        chk("ovf_beat_count", 32'(beats - b0), 8);
        chk("ovf_in_ready_recovered", 32'(in_ready), 1);
        chk("ovf_err_sticky", 32'(err_overflow), 1);
    endtask

    task automatic test_stall;
        bit t;
        bit held = 1'b0;
        logic [7:0] hpx;
        logic [1:0] hidx;
        int n = 0;
        out_ready = 1'b1;
        present(10 * 16384, 20 * 16384, 30 * 16384, 40 * 16384, t);
        while ((q.size() != 0 || out_valid) && n < 20) begin
            if (held) begin
                chk("stall_hold_px", 32'(out_pixel), 32'(hpx));
                chk("stall_hold_idx", 32'(out_idx), 32'(hidx));
            end
            out_ready = (n % 2 == 0);
            held = out_valid && !out_ready;
            hpx = out_pixel;
            hidx = out_idx;
            tick();
            n++;
        end
        chk("stall_finished", 32'(n < 20), 1);
        out_ready = 1'b1;
    endtask

    task automatic test_back_to_back;
        bit t;
        out_ready = 1'b0;
        present(50 * 16384, 51 * 16384, 52 * 16384, 53 * 16384, t);
        out_ready = 1'b1;
        repeat (3) tick();
        chk("b2b_idx3_showing", 32'(out_idx), 3);
        present(60 * 16384, 61 * 16384, 62 * 16384, 63 * 16384, t);
        chk("b2b_taken", 32'(t), 1);
        chk("b2b_no_bubble_valid", 32'(out_valid), 1);
        chk("b2b_next_idx0", 32'(out_idx), 0);
        chk("b2b_next_px", 32'(out_pixel), 60);
        chk("b2b_count_one", 32'(in_ready), 1);
        drain("b2b", 20);
    endtask

    task automatic test_reset_mid;
        bit t;
        bit seen = 1'b0;
        out_ready = 1'b1;
        present(70 * 16384, 71 * 16384, 72 * 16384, 73 * 16384, t);
        repeat (2) tick();
        chk("mid_at_idx2", 32'(out_idx), 2);
        rst = 1'b1;
        #1;
        chk("mid_async_valid", 32'(out_valid), 0);
        chk("mid_async_in_ready", 32'(in_ready), 0);
        chk("mid_err_cleared", 32'(err_overflow), 0);
        q.delete();
        @(negedge clk);
        rst = 1'b0;
        tick();
        chk("mid_in_ready_after", 32'(in_ready), 1);
        for (int i = 0; i < 8; i++) begin
            if (out_valid) seen = 1'b1;
            tick();
        end
        chk("mid_no_residual", 32'(seen), 0);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_clamp();
        test_overflow();
        test_stall();
        test_back_to_back();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got no completion, required completion");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/bicubic_product_serializer.md
BICUBIC_PRODUCT_SERIALIZER -- requirements
Module: bicubic_product_serializer

Interface
REQ-001 SHALL have parameter PRODUCT_WIDTH, default 32: width of each signed fixed-point inner product.
REQ-002 SHALL have parameter FRAC_BITS, default 14: fractional bits in each inner product, range 1..PRODUCT_WIDTH-2.
REQ-003 SHALL have parameter OUT_WIDTH, default 8: width of each output pixel.
REQ-004 SHALL have one clock, single clock domain; reset asynchronous, active-high, as fixed below.
REQ-005 SHALL have port clk  input  1  clock; all state updates on rising edge.
REQ-006 SHALL have port rst  input  1  asynchronous active-high reset.
REQ-007 SHALL have port in_valid  input  1  group of four inner products valid this cycle.
REQ-008 SHALL have port in_ready  output  1  block can accept a group this cycle.
REQ-009 SHALL have ports inner_product1..inner_product4  input  PRODUCT_WIDTH each  signed products of one weight-matrix row set.
REQ-010 SHALL have port out_valid  output  1  out_pixel valid.
REQ-011 SHALL have port out_ready  input  1  downstream accepts out_pixel.
REQ-012 SHALL have port out_pixel  output  OUT_WIDTH  rounded, clamped pixel.
REQ-013 SHALL have port out_idx  output  2  source index (0 = inner_product1 .. 3 = inner_product4).
REQ-014 SHALL have port out_last  output  1  high when out_idx == 3.
REQ-015 SHALL have port err_overflow  output  1  sticky: a group arrived while in_ready was low.

Function
REQ-016 SHALL accept a group when in_valid && in_ready at a rising edge; no other cycle captures inputs.
REQ-017 SHALL convert each product at capture: add 2^(FRAC_BITS-1), arithmetic shift right FRAC_BITS (round half up).
REQ-018 SHALL clamp the rounded value: < 0 -> 0; > 2^OUT_WIDTH-1 -> 2^OUT_WIDTH-1; else the value truncated to OUT_WIDTH.
REQ-019 SHALL perform the rounding addition at PRODUCT_WIDTH+1 bits so the most positive product does not wrap.
REQ-020 SHALL store converted groups in a 2-entry FIFO (4 x OUT_WIDTH per entry) with 1-bit read/write pointers and 2-bit count.
REQ-021 SHALL drive in_ready as a register output equal to (count < 2), excluding any same-cycle pop.
REQ-022 SHALL use a 2-state FSM: IDLE (count == 0, out_valid 0) and SEND (count > 0, out_valid 1).
REQ-023 SHALL transition IDLE -> SEND on the edge that captures a group; out_valid rises the next cycle (latency 1 clock, capture to first pixel).
REQ-024 SHALL present the head entry's pixels in order idx 0,1,2,3; a 2-bit beat counter advances only on out_valid && out_ready.
REQ-025 SHALL pop the head entry and reset the beat counter to 0 on the accepted beat with out_last = 1.
REQ-026 SHALL go SEND -> IDLE after that pop when count becomes 0; otherwise it SHALL stay in SEND and present the next entry's idx 0 on the following cycle with no bubble.
REQ-027 SHALL, on a same-edge capture and pop, leave count unchanged and advance both pointers.
REQ-028 SHALL hold out_pixel, out_idx, out_last stable while out_valid && !out_ready.
REQ-029 SHALL discard a group presented with in_valid && !in_ready, leave FIFO contents unchanged, and set err_overflow.
REQ-030 SHALL clear err_overflow only by reset.

Reset
REQ-031 SHALL, while rst = 1 and asynchronously, force: count, pointers, beat counter = 0; FSM = IDLE; out_valid = 0; out_pixel = 0; out_idx = 0; out_last = 0; err_overflow = 0; in_ready = 0.
REQ-032 SHALL drive in_ready = 1 on the first rising edge after rst deasserts.
REQ-033 SHALL discard any partially transmitted group when reset is asserted mid-operation; no beat of it appears after reset.

Verification (FRAC_BITS = 14, OUT_WIDTH = 8)
REQ-034 SHALL pass: products {100*2^14, 0, 255*2^14, 7*2^14+8192}, out_ready = 1 -> out_valid 1 clock later; pixels 100, 0, 255, 8 on consecutive cycles, out_last only on the 4th.
REQ-035 SHALL pass: products {-5, -2^31, 300*2^14, 2^31-1}, out_ready = 1 -> pixels 0, 0, 255, 255.
REQ-036 SHALL pass: three back-to-back groups with out_ready = 0 -> first two accepted; in_ready low from the edge of the 2nd capture; 3rd dropped; err_overflow = 1; after out_ready = 1, exactly 8 beats.
REQ-037 SHALL pass: out_ready toggled 1,0,1,0 during one group -> each pixel held until accepted; idx sequence 0,1,2,3 with no skips or repeats.
REQ-038 SHALL pass: with one entry queued, new group captured on the same edge as the out_last acceptance -> count stays 1; next group's idx 0 appears the next cycle.
REQ-039 SHALL pass: rst asserted after beat idx 1 -> out_valid 0 immediately (asynchronous); after release, in_ready = 1 and no residual beats.
